jtframe_romrq_rnd: RTL and testbench
====================================

JTFRAME_ROMRQ_RND -- requirements
Module: jtframe_romrq_rnd

Interface
REQ-001 SHALL have parameter AW, default 22, meaning the address width of addr, offset and sdram_addr.
REQ-002 SHALL have parameter DW, default 16, meaning the dout width; legal values are 8 and 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1 bit: invalidates the read cache.
REQ-006 SHALL have port offset, input, AW bits: added to the word address to form sdram_addr.
REQ-007 SHALL have port addr, input, AW bits: requested data address in DW units.
REQ-008 SHALL have port addr_ok, input, 1 bit: addr is valid and a read is requested.
REQ-009 SHALL have port din, input, 32 bits: fill data returned by the SDRAM.
REQ-010 SHALL have port din_ok, input, 1 bit: din is valid this cycle.
REQ-011 SHALL have port we, input, 1 bit: the SDRAM transaction for this requester is in progress, so a fill is accepted.
REQ-012 SHALL have port req, output, 1 bit: requests an SDRAM read.
REQ-013 SHALL have port data_ok, output, 1 bit: dout is valid for addr.
REQ-014 SHALL have port sdram_addr, output, AW bits: address presented to the SDRAM.
REQ-015 SHALL have port dout, output, DW bits: the selected data.
REQ-016 SHALL have port adv, input, 1 bit: advances the pseudo-random generator.
REQ-017 SHALL have port lfsr, output, 16 bits: the pseudo-random value.

Function
REQ-018 SHALL form the 32-bit word address addr_req as follows.
- DW=16: {addr[AW-1:1], 1'b0}.
- DW=8: {addr[AW-1:2], 2'b00}.
REQ-019 SHALL drive sdram_addr combinationally as addr_req + offset, modulo 2^AW, with wrap-around discarded.
REQ-020 SHALL hold two cache entries, each holding a valid bit, a 32-bit data word and an AW-bit tag.
REQ-021 SHALL define hitN as validN && (tagN == addr_req); hit means hit0 || hit1.
REQ-022 SHALL drive req combinationally as addr_ok && !hit && !we.
REQ-023 SHALL drive data_ok combinationally as addr_ok && hit, so a hit gives zero-cycle latency.
REQ-024 SHALL, on a rising edge with din_ok && we && !clr, write din and the current addr_req into the entry selected by a victim pointer, set that entry valid, and toggle the pointer.
- The pointer gives round-robin replacement.
- A hit becomes visible the cycle after the fill edge.
REQ-025 SHALL ignore din_ok while we is low.
REQ-026 SHALL, when clr is high at a rising edge, clear both valid bits and reset the victim pointer to entry 0.
- Any simultaneous fill is discarded; clr takes priority.
REQ-027 SHALL select dout from the hitting entry, with entry 0 taking precedence when both entries hit.
- DW=16: addr[0]=0 selects data[15:0]; addr[0]=1 selects data[31:16].
- DW=8: addr[1:0] selects byte 0 to 3, with byte 0 being data[7:0].
REQ-028 SHALL drive dout from the entry-0 selection when there is no hit; dout has no meaning while data_ok is low.
REQ-029 SHALL implement the LFSR as a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1.
- On a rising edge with adv=1, it updates to {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- With adv=0 it holds its value.
REQ-030 SHALL never reach the all-zero LFSR state; the sequence period is 65535.
REQ-031 SHALL keep the cache and the LFSR independent, with no interaction between them.

Reset
REQ-032 SHALL, while rst is high at a rising edge, clear both valid bits, the victim pointer, both tags and both data words, and load lfsr with 16'h0001.
- Reset has priority over clr, fill and adv.
REQ-033 SHALL produce, during and after reset, req = addr_ok && !we and data_ok = 0 until the first fill.
REQ-034 SHALL lose any fill that is mid-flight when reset is asserted; no partial entry survives.

Verification
REQ-035 The bench SHALL check miss then fill with AW=22, DW=16, offset=0.
- Stimulus: addr=22'h000005, addr_ok=1, we=0.
- Response: req=1 and sdram_addr=22'h000004.
- Then with we=1 and din=32'hBEEF1234 plus din_ok for one cycle, the next cycle gives data_ok=1 and dout=16'hBEEF.
- With addr=22'h000004, dout=16'h1234.
REQ-036 The bench SHALL check offset wrap.
- Stimulus: offset=22'h3FFFFE, addr=22'h000006.
- Response: sdram_addr=22'h000004.
REQ-037 The bench SHALL check replacement.
- Stimulus: fill tags 0, 2 and 4 in that order.
- Response: tag 0 is evicted, so addr=0 gives req=1 and data_ok=0, while addr=2 and addr=4 hit.
REQ-038 The bench SHALL check clr.
- Stimulus: after a valid fill, pulse clr for one cycle.
- Response: the next cycle gives data_ok=0 and req=1 for the same addr.
- clr coincident with din_ok&&we leaves no valid entry.
REQ-039 The bench SHALL check the LFSR sequence.
- Stimulus: after reset with adv=1.
- Response: lfsr=16'h0001, then 16'h0002, 16'h0004, 16'h0008, ...
- After 65535 advances, lfsr=16'h0001 again and 16'h0000 never occurs.
- With adv=0 the value holds.
REQ-040 The bench SHALL check reset mid-operation.
- Stimulus: assert rst while we=1 and din_ok=1.
- Response: the next cycle gives data_ok=0 and lfsr=16'h0001.

Source files
------------

// File: rtl/jtframe_romrq_rnd.sv
// Two-entry round-robin read cache in front of a 32-bit SDRAM port, with a
// free-running 16-bit Fibonacci LFSR sharing the same clock and reset.
module jtframe_romrq_rnd #(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  input  logic [31:0]   din,
  input  logic          din_ok,
  input  logic          we,
  output logic          req,
  output logic          data_ok,
  output logic [AW-1:0] sdram_addr,
  output logic [DW-1:0] dout,
  input  logic          adv,
  output logic [15:0]   lfsr
);

  logic [AW-1:0] addr_req_s;
  logic          hit0_s;
  logic          hit1_s;
  logic          hit_s;
  logic          sel_s;
  logic [31:0]   word_s;

  logic          valid_r [2];
  logic [AW-1:0] tag_r   [2];
  logic [31:0]   data_r  [2];
  logic          victim_r;
  logic [15:0]   lfsr_r;

  // Align the requested address down to a 32-bit word boundary
  always_comb begin
    addr_req_s = addr;
    if (DW == 8) begin
      addr_req_s = {addr[AW-1:2], 2'b00};
    end else begin
      addr_req_s = {addr[AW-1:1], 1'b0};
    end
  end

  // Tag lookup and request/handshake generation
  always_comb begin
    hit0_s     = valid_r[0] && (tag_r[0] == addr_req_s);
    hit1_s     = valid_r[1] && (tag_r[1] == addr_req_s);
    hit_s      = hit0_s || hit1_s;
    sel_s      = !hit0_s && hit1_s;
    word_s     = sel_s ? data_r[1] : data_r[0];
    req        = addr_ok && !hit_s && !we;
    data_ok    = addr_ok && hit_s;
    sdram_addr = addr_req_s + offset;
  end

  generate
    if (DW == 8) begin : g_byte
      // Byte lane select inside the hitting word
      always_comb begin
        case (addr[1:0])
          2'd0:    dout = word_s[7:0];
          2'd1:    dout = word_s[15:8];
          2'd2:    dout = word_s[23:16];
          2'd3:    dout = word_s[31:24];
          default: dout = word_s[7:0];
        endcase
      end
    end else begin : g_half
      // Half-word select inside the hitting word
      always_comb begin
        if (addr[0]) begin
          dout = word_s[31:16];
        end else begin
          dout = word_s[15:0];
        end
      end
    end
  endgenerate

  // Cache storage: reset beats clr, clr beats a coincident fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r[0] <= 1'b0;
      valid_r[1] <= 1'b0;
      tag_r[0]   <= '0;
      tag_r[1]   <= '0;
      data_r[0]  <= 32'h0000_0000;
      data_r[1]  <= 32'h0000_0000;
      victim_r   <= 1'b0;
    end else if (clr) begin
      valid_r[0] <= 1'b0;
      valid_r[1] <= 1'b0;
      victim_r   <= 1'b0;
    end else if (din_ok && we) begin
      data_r[victim_r]  <= din;
      tag_r[victim_r]   <= addr_req_s;
      valid_r[victim_r] <= 1'b1;
      victim_r          <= ~victim_r;
    end
  end

  // Taps 16,14,13,11 give a maximal-length sequence that never reaches zero
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 16'h0001;
    end else if (adv) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: tb/tb_jtframe_romrq_rnd.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor
// pops and compares them against the live DUT outputs.
`timescale 1ns/1ps
module tb_jtframe_romrq_rnd;

  logic        clk = 1'b0;
  logic        rst, clr, addr_ok, din_ok, we, adv;
  logic [21:0] offset, addr;
  logic [31:0] din;
  logic        req, data_ok;
  logic [21:0] sdram_addr;
  logic [15:0] dout, lfsr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          c_req;  logic        e_req;
    bit          c_ok;   logic        e_ok;
    bit          c_dout; logic [15:0] e_dout;
    bit          c_addr; logic [21:0] e_addr;
    bit          c_lfsr; logic [15:0] e_lfsr;
  } exp_t;

  exp_t sb[$];

  jtframe_romrq_rnd #(.AW(22), .DW(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr),
    .addr_ok(addr_ok), .din(din), .din_ok(din_ok), .we(we), .req(req),
    .data_ok(data_ok), .sdram_addr(sdram_addr), .dout(dout), .adv(adv),
    .lfsr(lfsr)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t blank(input string n);
    exp_t e;
    e.name = n;
    e.c_req = 0; e.e_req = 0; e.c_ok = 0; e.e_ok = 0;
    e.c_dout = 0; e.e_dout = 0; e.c_addr = 0; e.e_addr = 0;
    e.c_lfsr = 0; e.e_lfsr = 0;
    return e;
  endfunction

  task automatic expect_io(input string n, input logic r, input logic ok,
                           input bit cd, input logic [15:0] d);
    exp_t e;
    e = blank(n);
    e.c_req = 1; e.e_req = r; e.c_ok = 1; e.e_ok = ok;
    e.c_dout = cd; e.e_dout = d;
    sb.push_back(e);
  endtask

  task automatic expect_addr(input string n, input logic [21:0] a);
    exp_t e;
    e = blank(n);
    e.c_addr = 1; e.e_addr = a;
    sb.push_back(e);
  endtask

  task automatic expect_lfsr(input string n, input logic [15:0] v);
    exp_t e;
    e = blank(n);
    e.c_lfsr = 1; e.e_lfsr = v;
    sb.push_back(e);
  endtask

  // Monitor: drain every expectation queued for this cycle
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.c_req) begin
        checks++;
        if (req !== e.e_req) begin
          failures++;
          $display("FAIL %s.req got=%0h want=%0h", e.name, req, e.e_req);
        end
      end
      if (e.c_ok) begin
        checks++;
        if (data_ok !== e.e_ok) begin
          failures++;
          $display("FAIL %s.data_ok got=%0h want=%0h", e.name, data_ok, e.e_ok);
        end
      end
      if (e.c_dout) begin
        checks++;
        if (dout !== e.e_dout) begin
          failures++;
          $display("FAIL %s.dout got=%h want=%h", e.name, dout, e.e_dout);
        end
      end
      if (e.c_addr) begin
        checks++;
        if (sdram_addr !== e.e_addr) begin
          failures++;
          $display("FAIL %s.sdram_addr got=%h want=%h", e.name, sdram_addr, e.e_addr);
        end
      end
      if (e.c_lfsr) begin
        checks++;
        if (lfsr !== e.e_lfsr) begin
          failures++;
          $display("FAIL %s.lfsr got=%h want=%h", e.name, lfsr, e.e_lfsr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [21:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1; din_ok = 1'b1;
    tick();
    we = 1'b0; din_ok = 1'b0;
  endtask

  logic [15:0] lfsr_tbl [8];
  bit          lfsr_bad;

  initial begin
    lfsr_tbl = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                 16'h0010, 16'h0020, 16'h0040, 16'h0080};
    rst = 1'b1; clr = 1'b0; addr_ok = 1'b1; din_ok = 1'b0; we = 1'b0;
    adv = 1'b0; offset = 22'h0; addr = 22'h000005; din = 32'h0;
    tick();
    expect_io("reset_io", 1'b1, 1'b0, 0, 16'h0);
    expect_lfsr("reset_lfsr", 16'h0001);
    tick();
    rst = 1'b0;

    // miss then fill
    expect_io("miss_io", 1'b1, 1'b0, 0, 16'h0);
    expect_addr("miss_addr", 22'h000004);
    tick();
    addr = 22'h000005; din = 32'hBEEF1234; we = 1'b1; din_ok = 1'b1;
    expect_io("fill_we_io", 1'b0, 1'b0, 0, 16'h0);
    tick();
    we = 1'b0; din_ok = 1'b0;
    expect_io("hit_hi", 1'b0, 1'b1, 1, 16'hBEEF);
    tick();
    addr = 22'h000004;
    expect_io("hit_lo", 1'b0, 1'b1, 1, 16'h1234);
    tick();

    // offset wrap
    offset = 22'h3FFFFE; addr = 22'h000006;
    expect_addr("wrap_addr", 22'h000004);
    expect_io("wrap_io", 1'b1, 1'b0, 0, 16'h0);
    tick();
    offset = 22'h0;

    // round-robin replacement from a cleared cache
    clr = 1'b1;
    tick();
    clr = 1'b0;
    fill(22'h000000, 32'h11110000);
    fill(22'h000002, 32'h22223333);
    fill(22'h000004, 32'h44445555);
    addr = 22'h000000;
    expect_io("evict_0", 1'b1, 1'b0, 0, 16'h0);
    tick();
    addr = 22'h000002;
    expect_io("keep_2", 1'b0, 1'b1, 1, 16'h3333);
    tick();
    addr = 22'h000003;
    expect_io("keep_3", 1'b0, 1'b1, 1, 16'h2222);
    tick();
    addr = 22'h000005;
    expect_io("keep_5", 1'b0, 1'b1, 1, 16'h4444);
    tick();

    // both entries share tag 4: entry 0 wins
    fill(22'h000004, 32'h88889999);
    addr = 22'h000004;
    expect_io("prio_e0", 1'b0, 1'b1, 1, 16'h5555);
    tick();

    // clr invalidates on the following cycle
    clr = 1'b1;
    expect_io("clr_same_cycle", 1'b0, 1'b1, 1, 16'h5555);
    tick();
    clr = 1'b0;
    expect_io("clr_after", 1'b1, 1'b0, 0, 16'h0);
    tick();

    // clr coincident with a fill
    addr = 22'h000004; din = 32'hDEADBEEF; we = 1'b1; din_ok = 1'b1; clr = 1'b1;
    tick();
    we = 1'b0; din_ok = 1'b0; clr = 1'b0;
    expect_io("clr_vs_fill", 1'b1, 1'b0, 0, 16'h0);
    tick();

    // din_ok ignored without we
    addr = 22'h000008; din = 32'h0BADF00D; din_ok = 1'b1;
    tick();
    din_ok = 1'b0;
    expect_io("no_we_fill", 1'b1, 1'b0, 0, 16'h0);
    tick();

    // LFSR sequence and full period
    rst = 1'b1;
    tick();
    rst = 1'b0;
    adv = 1'b1;
    lfsr_bad = 0;
    for (int i = 0; i < 65535; i++) begin
      if (i < 8) expect_lfsr($sformatf("lfsr_step%0d", i), lfsr_tbl[i]);
      if (lfsr === 16'h0000 || (i > 0 && lfsr === 16'h0001)) lfsr_bad = 1;
      tick();
    end
    checks++;
    if (lfsr_bad) begin
      failures++;
      $display("FAIL lfsr_period got=zero_or_short want=period_65535");
    end
    expect_lfsr("lfsr_wrap", 16'h0001);
    tick();
    adv = 1'b0;
    expect_lfsr("lfsr_adv1", 16'h0002);
    tick();
    expect_lfsr("lfsr_hold", 16'h0002);
    tick();

    // reset in the middle of a fill
    fill(22'h000008, 32'hCAFEF00D);
    addr = 22'h000008;
    expect_io("pre_rst_hit", 1'b0, 1'b1, 1, 16'hF00D);
    tick();
    we = 1'b1; din_ok = 1'b1; din = 32'h12345678; rst = 1'b1; adv = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; din_ok = 1'b0; adv = 1'b0;
    expect_io("rst_mid_io", 1'b1, 1'b0, 0, 16'h0);
    expect_lfsr("rst_mid_lfsr", 16'h0001);
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
